// File: rtl/unidad_control_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : unidad_control_multiciclo
// Brief    : Main control FSM for the multi-cycle MIPS-subset datapath.
//            It sequences fetch, decode, execute, memory and write-back for
//            R-type, lw, sw, beq and j. Each cycle it drives the datapath
//            enables, the mux selects and the ALU-operation class (dataUC).
// Ports    : clk, rst_n (async, active-low)
//            Opcode[5:0]   IR[31:26], sampled in DECODE
//            mem_ready     memory handshake (FETCH, MEM_READ, MEM_WRITE only)
//            dataUC[2:0]   ALU class: 000 add, 001 sub, 010 R-type
//            PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//            MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], PCSource[1:0]
//            instr_done    pulse in the last cycle of every instruction
//            illegal_op    sticky undefined-opcode flag
// Options  : UC_ILLEGAL_TRAP_EN defined   -> illegal opcode enters TRAP and
//                                           sets illegal_op until reset.
//            UC_ILLEGAL_TRAP_EN undefined -> illegal opcode executes as NOP,
//                                           illegal_op tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module unidad_control_multiciclo #(
    parameter int unsigned W_STATE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic [2:0] dataUC,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    typedef enum logic [W_STATE-1:0] {
        st_idle      = 4'd0,
        st_fetch     = 4'd1,
        st_decode    = 4'd2,
        st_mem_addr  = 4'd3,
        st_mem_read  = 4'd4,
        st_mem_wb    = 4'd5,
        st_mem_write = 4'd6,
        st_exec_r    = 4'd7,
        st_r_wb      = 4'd8,
        st_branch    = 4'd9,
`ifdef UC_ILLEGAL_TRAP_EN
        st_jump      = 4'd10,
        st_trap      = 4'd11
`else
        st_jump      = 4'd10
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_opcode;   // opcode captured on DECODE exit

    // State and opcode register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= st_idle;
            r_opcode <= 6'b000000;
        end else begin
            r_state <= w_next;
            if (r_state == st_decode) begin
                r_opcode <= Opcode;
            end
        end
    end

`ifdef UC_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky flag: set on the edge that enters TRAP, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_next == st_trap) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal_op = r_illegal;
`else
    assign illegal_op = 1'b0;
`endif

    // Next-state and output decode
    always_comb begin
        w_next      = r_state;
        dataUC      = 3'b000;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;

        case (r_state)
            st_idle: begin
                w_next = st_fetch;
            end
            st_fetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR and PC may only update in the cycle the read completes
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = st_decode;
                end
            end
            st_decode: begin
                ALUSrcB = 2'b11;    // branch target precomputed here
                case (Opcode)
                    c_OP_RTYPE:      w_next = st_exec_r;
                    c_OP_LW, c_OP_SW: w_next = st_mem_addr;
                    c_OP_BEQ:        w_next = st_branch;
                    c_OP_J:          w_next = st_jump;
                    default: begin
`ifdef UC_ILLEGAL_TRAP_EN
                        w_next = st_trap;
`else
                        // Undefined opcode retires as a NOP
                        w_next     = st_fetch;
                        instr_done = 1'b1;
`endif
                    end
                endcase
            end
            st_mem_addr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // Only lw or sw can reach this state
                w_next  = (r_opcode == c_OP_SW) ? st_mem_write : st_mem_read;
            end
            st_mem_read: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    w_next = st_mem_wb;
                end
            end
            st_mem_wb: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
                w_next     = st_fetch;
            end
            st_mem_write: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = st_fetch;
                end
            end
            st_exec_r: begin
                ALUSrcA = 1'b1;
                dataUC  = 3'b010;
                w_next  = st_r_wb;
            end
            st_r_wb: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = st_fetch;
            end
            st_branch: begin
                ALUSrcA     = 1'b1;
                dataUC      = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                w_next      = st_fetch;
            end
            st_jump: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                w_next     = st_fetch;
            end
`ifdef UC_ILLEGAL_TRAP_EN
            st_trap: begin
                w_next = st_trap;
            end
`endif
            default: begin
                w_next = st_idle;
            end
        endcase
    end

endmodule
`default_nettype wire
